// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its neighbours: the PC,
// instruction memory and the decoder.
interface fetch_sequencer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] pc_in;
   logic             pc_inc;
   logic             pc_load;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] mem_addr;
   logic             mem_rd;
   logic [WIDTH-1:0] mem_data;
   logic             mem_ack;
   logic             jump_req;
   logic [WIDTH-1:0] jump_target;
   logic [WIDTH-1:0] ir_out;
   logic             ir_valid;
   logic             ir_ready;
   logic             fault;

   modport master (
      input  pc_in, mem_data, mem_ack, jump_req, jump_target, ir_ready,
      output pc_inc, pc_load, pc_d, mem_addr, mem_rd, ir_out, ir_valid, fault
   );

   modport slave (
      output pc_in, mem_data, mem_ack, jump_req, jump_target, ir_ready,
      input  pc_inc, pc_load, pc_d, mem_addr, mem_rd, ir_out, ir_valid, fault
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: reads memory at the PC, holds the word in the IR
// until the decoder takes it, applies branch redirects and traps memory timeouts.
module fetch_sequencer #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input logic               clk,
   input logic               reset,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t           state_r, state_s;
   logic [WIDTH-1:0] ir_out_r, ir_out_s;
   logic             ir_valid_r, ir_valid_s;
   logic             fault_r, fault_s;
   logic             abort_r, abort_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             mem_rd_s, pc_inc_s, pc_load_s;

   // State and IR registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_START;
         ir_out_r   <= {WIDTH{1'b0}};
         ir_valid_r <= 1'b0;
         fault_r    <= 1'b0;
         abort_r    <= 1'b0;
         cnt_r      <= CNT_ZERO;
      end else begin
         state_r    <= state_s;
         ir_out_r   <= ir_out_s;
         ir_valid_r <= ir_valid_s;
         fault_r    <= fault_s;
         abort_r    <= abort_s;
         cnt_r      <= cnt_s;
      end
   end

   // Next-state and Mealy PC/memory controls; abort_r marks the one-cycle read gap after a redirect
   always_comb begin
      state_s    = state_r;
      ir_out_s   = ir_out_r;
      ir_valid_s = ir_valid_r;
      fault_s    = fault_r;
      abort_s    = 1'b0;
      cnt_s      = cnt_r;
      mem_rd_s   = 1'b0;
      pc_inc_s   = 1'b0;
      pc_load_s  = 1'b0;
      case (state_r)
         S_START: begin
            state_s = S_FETCH;
            cnt_s   = CNT_ZERO;
         end
         S_FETCH: begin
            mem_rd_s = ~abort_r;
            if (bus.jump_req) begin
               pc_load_s  = 1'b1;
               ir_valid_s = 1'b0;
               abort_s    = 1'b1;
               cnt_s      = CNT_ZERO;
               state_s    = S_FETCH;
            end else if (abort_r) begin
               state_s = S_FETCH;
            end else if (bus.mem_ack) begin
               ir_out_s   = bus.mem_data;
               ir_valid_s = 1'b1;
               pc_inc_s   = 1'b1;
               state_s    = S_HOLD;
            end else if (cnt_r == CNT_LAST) begin
               fault_s = 1'b1;
               state_s = S_FAULT;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         S_HOLD: begin
            if (bus.jump_req) begin
               pc_load_s  = 1'b1;
               ir_valid_s = 1'b0;
               abort_s    = 1'b1;
               cnt_s      = CNT_ZERO;
               state_s    = S_FETCH;
            end else if (bus.ir_ready) begin
               ir_valid_s = 1'b0;
               cnt_s      = CNT_ZERO;
               state_s    = S_FETCH;
            end else begin
               state_s = S_HOLD;
            end
         end
         S_FAULT: begin
            fault_s = 1'b1;
            state_s = S_FAULT;
         end
         default: begin
            state_s = S_START;
         end
      endcase
   end

   assign bus.mem_rd   = mem_rd_s;
   assign bus.pc_inc   = pc_inc_s;
   assign bus.pc_load  = pc_load_s;
   assign bus.pc_d     = bus.jump_target;
   assign bus.mem_addr = bus.pc_in;
   assign bus.ir_out   = ir_out_r;
   assign bus.ir_valid = ir_valid_r;
   assign bus.fault    = fault_r;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with a behavioural PC in the loop.
module tb_fetch_sequencer;
   typedef struct {
      logic        jump_req;
      logic        mem_ack;
      logic        ir_ready;
      logic [15:0] mem_data;
      logic [15:0] jump_target;
      logic        e_rd;
      logic        e_inc;
      logic        e_ld;
      logic        e_valid;
      logic        e_fault;
      logic [15:0] e_ir;
      logic [15:0] e_addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_preset = 1'b1;
   logic [15:0] pc_preset_val = 16'h0010;
   logic [15:0] pc = 16'h0000;
   int          errors = 0;
   int          checks = 0;
   int          cur_vec = -1;
   vec_t        vq[$];

   fetch_sequencer_if #(.WIDTH(16)) bus ();

   fetch_sequencer #(.WIDTH(16), .TIMEOUT(15), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Program counter model that the sequencer steers
   always @(posedge clk) begin
      if (pc_preset)        pc <= pc_preset_val;
      else if (bus.pc_load) pc <= bus.pc_d;
      else if (bus.pc_inc)  pc <= pc + 16'h0001;
   end
   assign bus.pc_in = pc;

   function automatic vec_t mk(input logic jr, input logic ack, input logic rdy,
                               input logic [15:0] data, input logic [15:0] jt,
                               input logic rd, input logic inc, input logic ld,
                               input logic v, input logic f,
                               input logic [15:0] ir, input logic [15:0] addr);
      vec_t r;
      r.jump_req = jr;  r.mem_ack = ack; r.ir_ready = rdy;
      r.mem_data = data; r.jump_target = jt;
      r.e_rd = rd; r.e_inc = inc; r.e_ld = ld; r.e_valid = v; r.e_fault = f;
      r.e_ir = ir; r.e_addr = addr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got %h, expected %h", name, cur_vec, act, exp);
      end
   endtask

   task automatic drive(input logic jr, input logic ack, input logic rdy,
                        input logic [15:0] data, input logic [15:0] jt);
      bus.jump_req = jr; bus.mem_ack = ack; bus.ir_ready = rdy;
      bus.mem_data = data; bus.jump_target = jt;
   endtask

   initial begin
      // fetch at 0x0010, ack on 3rd read cycle
      vq.push_back(mk(1'b1,1'b0,1'b0,16'h0000,16'h0300, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0010));
      vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0010));
      vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0010));
      vq.push_back(mk(1'b0,1'b1,1'b0,16'hA5C3,16'h0000, 1'b1,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0010));
      // decoder stalls three cycles then accepts
      for (int i = 0; i < 3; i++)
         vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,16'hA5C3,16'h0011));
      vq.push_back(mk(1'b0,1'b0,1'b1,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b1,1'b0,16'hA5C3,16'h0011));
      vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,16'hA5C3,16'h0011));
      // redirect collides with ack; stale ack in the abort cycle is ignored
      vq.push_back(mk(1'b1,1'b1,1'b0,16'h1234,16'h0200, 1'b1,1'b0,1'b1,1'b0,1'b0,16'hA5C3,16'h0011));
      vq.push_back(mk(1'b0,1'b1,1'b0,16'hDEAD,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'hA5C3,16'h0200));
      vq.push_back(mk(1'b0,1'b1,1'b0,16'h5A5A,16'h0000, 1'b1,1'b1,1'b0,1'b0,1'b0,16'hA5C3,16'h0200));
      // redirect in HOLD together with ir_ready
      vq.push_back(mk(1'b1,1'b0,1'b1,16'h0000,16'h0400, 1'b0,1'b0,1'b1,1'b1,1'b0,16'h5A5A,16'h0201));
      vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h5A5A,16'h0400));
      // 14 unacked reads, then a redirect on the would-be timeout cycle
      for (int i = 0; i < 14; i++)
         vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h5A5A,16'h0400));
      vq.push_back(mk(1'b1,1'b0,1'b0,16'h0000,16'h0600, 1'b1,1'b0,1'b1,1'b0,1'b0,16'h5A5A,16'h0400));
      vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0,16'h5A5A,16'h0600));
      // full 15-cycle timeout -> fault, inputs ignored afterwards
      for (int i = 0; i < 15; i++)
         vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0,16'h5A5A,16'h0600));
      vq.push_back(mk(1'b1,1'b0,1'b0,16'h0000,16'h0700, 1'b0,1'b0,1'b0,1'b0,1'b1,16'h5A5A,16'h0600));
      vq.push_back(mk(1'b0,1'b1,1'b1,16'hBEEF,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b1,16'h5A5A,16'h0600));
      vq.push_back(mk(1'b0,1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b1,16'h5A5A,16'h0600));

      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      chk("reset_mem_rd",  {15'd0, bus.mem_rd},   16'h0000);
      chk("reset_pc_inc",  {15'd0, bus.pc_inc},   16'h0000);
      chk("reset_pc_load", {15'd0, bus.pc_load},  16'h0000);
      chk("reset_ir_valid",{15'd0, bus.ir_valid}, 16'h0000);
      chk("reset_fault",   {15'd0, bus.fault},    16'h0000);
      chk("reset_ir_out",  bus.ir_out,            16'h0000);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      pc_preset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         cur_vec = i;
         drive(vq[i].jump_req, vq[i].mem_ack, vq[i].ir_ready, vq[i].mem_data, vq[i].jump_target);
         #1;
         chk("mem_rd",   {15'd0, bus.mem_rd},   {15'd0, vq[i].e_rd});
         chk("pc_inc",   {15'd0, bus.pc_inc},   {15'd0, vq[i].e_inc});
         chk("pc_load",  {15'd0, bus.pc_load},  {15'd0, vq[i].e_ld});
         chk("ir_valid", {15'd0, bus.ir_valid}, {15'd0, vq[i].e_valid});
         chk("fault",    {15'd0, bus.fault},    {15'd0, vq[i].e_fault});
         chk("ir_out",   bus.ir_out,            vq[i].e_ir);
         chk("mem_addr", bus.mem_addr,          vq[i].e_addr);
         chk("pc_d",     bus.pc_d,              vq[i].jump_target);
         @(negedge clk);
      end

      // reset clears the sticky fault
      cur_vec = 1000;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      reset = 1'b1;
      pc_preset = 1'b1;
      pc_preset_val = 16'h0800;
      #1;
      chk("fault_cleared", {15'd0, bus.fault},  16'h0000);
      chk("fault_rst_rd",  {15'd0, bus.mem_rd}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      pc_preset = 1'b0;
      #1;
      chk("start_idle_rd", {15'd0, bus.mem_rd}, 16'h0000);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      bus.mem_data = 16'h0F0F;
      #1;
      chk("refetch_rd",   {15'd0, bus.mem_rd}, 16'h0001);
      chk("refetch_addr", bus.mem_addr,        16'h0800);
      chk("refetch_inc",  {15'd0, bus.pc_inc}, 16'h0001);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      chk("hold_valid", {15'd0, bus.ir_valid}, 16'h0001);
      chk("hold_ir",    bus.ir_out,            16'h0F0F);

      // asynchronous reset mid-cycle while an instruction is held
      #2;
      reset = 1'b1;
      #1;
      chk("async_valid", {15'd0, bus.ir_valid}, 16'h0000);
      chk("async_ir",    bus.ir_out,            16'h0000);
      chk("async_rd",    {15'd0, bus.mem_rd},   16'h0000);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_idle_rd", {15'd0, bus.mem_rd}, 16'h0000);
      @(negedge clk);
      #1;
      chk("post_fetch_rd", {15'd0, bus.mem_rd}, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
